// File: rtl/tandy_kb_pkg.sv
// ---------------------------------------------------------------------------
// tandy_kb_pkg
// Shared definitions for the Tandy 1000 <-> PC/XT set-1 keyboard code paths.
//   - enc_state_e    : byte-replay FSM states of the scancode encoder
//   - E0_PREFIX      : extended-key prefix byte
//   - REV_MAP        : Tandy key code -> {need_e0, XT code} table. The forward
//                      (XT -> Tandy) converter reads the same table, swapping
//                      columns, so both directions stay consistent.
// ---------------------------------------------------------------------------
package tandy_kb_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PRE_HI  = 3'd1,
      PRE_LO  = 3'd2,
      CODE_HI = 3'd3,
      CODE_LO = 3'd4
   } enc_state_e;

   localparam logic [7:0] E0_PREFIX = 8'hE0;

   // Entry layout: [14:8] Tandy code, [7] needs E0 prefix, [6:0] XT code.
   localparam int REV_MAP_N = 11;
   localparam logic [REV_MAP_N-1:0][14:0] REV_MAP = {
      {7'h29, 1'b1, 7'h48},   // up arrow
      {7'h2B, 1'b1, 7'h4B},   // left arrow
      {7'h4A, 1'b1, 7'h50},   // down arrow
      {7'h4E, 1'b1, 7'h4D},   // right arrow
      {7'h57, 1'b1, 7'h1C},   // keypad enter
      {7'h58, 1'b1, 7'h47},   // home
      {7'h53, 1'b0, 7'h4A},   // keypad minus
      {7'h55, 1'b0, 7'h4E},   // keypad plus
      {7'h56, 1'b0, 7'h53},   // keypad period / del
      {7'h59, 1'b0, 7'h57},   // F11
      {7'h5A, 1'b0, 7'h58}    // F12
   };

endpackage

// File: rtl/tandy_scancode_encoder_if.sv
// ---------------------------------------------------------------------------
// tandy_scancode_encoder_if
// Valid/ready handshake carrying one Tandy keyboard code per transfer.
//   tandy_code  : [7] break flag, [6:0] Tandy key code
//   tandy_valid : source offers a code
//   tandy_ready : encoder can accept (transfer when valid & ready on clock)
// master = code source, slave = encoder.
// ---------------------------------------------------------------------------
interface tandy_scancode_encoder_if;
   logic [7:0] tandy_code;
   logic       tandy_valid;
   logic       tandy_ready;

   modport master (
      output tandy_code,
      output tandy_valid,
      input  tandy_ready
   );

   modport slave (
      input  tandy_code,
      input  tandy_valid,
      output tandy_ready
   );
endinterface

// File: rtl/tandy_code_reverse_map.sv
// ---------------------------------------------------------------------------
// tandy_code_reverse_map
// Purely combinational Tandy key code -> XT set-1 key code lookup.
//   code_i    : 7-bit Tandy key code (break flag stripped)
//   need_e0_o : XT code must be preceded by an E0 prefix byte
//   code_o    : 7-bit XT key code (unmapped codes pass through)
// ---------------------------------------------------------------------------
module tandy_code_reverse_map
   import tandy_kb_pkg::*;
(
   input  logic [6:0] code_i,
   output logic       need_e0_o,
   output logic [6:0] code_o
);

   // Table lookup; table entries are unique so at most one can hit.
   always_comb begin
      need_e0_o = 1'b0;
      code_o    = code_i;
      for (int i = 0; i < REV_MAP_N; i++) begin
         if (code_i == REV_MAP[i][14:8]) begin
            need_e0_o = REV_MAP[i][7];
            code_o    = REV_MAP[i][6:0];
         end
      end
   end

endmodule

// File: rtl/tandy_scancode_encoder.sv
// ---------------------------------------------------------------------------
// tandy_scancode_encoder
// Accepts one Tandy 1000 keyboard code per handshake and replays it as one
// or two IRQ-framed PC/XT set-1 bytes (optional E0 prefix, then the mapped
// code carrying the break bit).
//   clock       : single clock domain
//   reset       : asynchronous, active-low
//   tandy       : slave side of the Tandy code valid/ready handshake
//   scancode    : XT byte currently presented (held across each IRQ pulse)
//   keybord_irq : byte strobe, high IRQ_HIGH_CYCLES then low IRQ_GAP_CYCLES
// ---------------------------------------------------------------------------
module tandy_scancode_encoder
   import tandy_kb_pkg::*;
#(
   parameter int IRQ_HIGH_CYCLES = 4,
   parameter int IRQ_GAP_CYCLES  = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   tandy_scancode_encoder_if.slave  tandy,
   output logic [7:0]               scancode,
   output logic                     keybord_irq
);

   localparam int MAX_CYC = (IRQ_HIGH_CYCLES > IRQ_GAP_CYCLES) ?
                            IRQ_HIGH_CYCLES : IRQ_GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(IRQ_HIGH_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(IRQ_GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   enc_state_e       state_q;
   logic [CNT_W-1:0] phase_q;
   logic [7:0]       byte_q;       // code byte captured at acceptance
   logic [7:0]       scancode_q;
   logic             irq_q;
   logic             ready_q;

   logic             need_e0_s;
   logic [6:0]       code7_s;

   tandy_code_reverse_map u_map (
      .code_i    (tandy.tandy_code[6:0]),
      .need_e0_o (need_e0_s),
      .code_o    (code7_s)
   );

   // Byte-replay FSM; every output is a register updated alongside the state,
   // so scancode and irq always change on the same edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         phase_q    <= CNT_ZERO;
         byte_q     <= 8'h00;
         scancode_q <= 8'h00;
         irq_q      <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               phase_q <= CNT_ZERO;
               if (tandy.tandy_valid) begin
                  byte_q  <= {tandy.tandy_code[7], code7_s};
                  irq_q   <= 1'b1;
                  ready_q <= 1'b0;
                  if (need_e0_s) begin
                     state_q    <= PRE_HI;
                     scancode_q <= E0_PREFIX;
                  end else begin
                     state_q    <= CODE_HI;
                     scancode_q <= {tandy.tandy_code[7], code7_s};
                  end
               end else begin
                  ready_q <= 1'b1;
               end
            end
            PRE_HI: begin
               if (phase_q == HI_LAST) begin
                  state_q <= PRE_LO;
                  phase_q <= CNT_ZERO;
                  irq_q   <= 1'b0;
               end else begin
                  phase_q <= phase_q + CNT_ONE;
               end
            end
            PRE_LO: begin
               if (phase_q == GAP_LAST) begin
                  state_q    <= CODE_HI;
                  phase_q    <= CNT_ZERO;
                  scancode_q <= byte_q;
                  irq_q      <= 1'b1;
               end else begin
                  phase_q <= phase_q + CNT_ONE;
               end
            end
            CODE_HI: begin
               if (phase_q == HI_LAST) begin
                  state_q <= CODE_LO;
                  phase_q <= CNT_ZERO;
                  irq_q   <= 1'b0;
               end else begin
                  phase_q <= phase_q + CNT_ONE;
               end
            end
            CODE_LO: begin
               if (phase_q == GAP_LAST) begin
                  state_q <= IDLE;
                  phase_q <= CNT_ZERO;
                  ready_q <= 1'b1;
               end else begin
                  phase_q <= phase_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= IDLE;
               phase_q <= CNT_ZERO;
               irq_q   <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign scancode          = scancode_q;
   assign keybord_irq       = irq_q;
   assign tandy.tandy_ready = ready_q;

endmodule

// File: tb/tb_tandy_scancode_encoder.sv
module tb_tandy_scancode_encoder;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] scancode;
   logic       keybord_irq;

   tandy_scancode_encoder_if tif ();

   tandy_scancode_encoder #(
      .IRQ_HIGH_CYCLES (4),
      .IRQ_GAP_CYCLES  (4)
   ) u_dut (
      .clock       (clock),
      .reset       (reset),
      .tandy       (tif.slave),
      .scancode    (scancode),
      .keybord_irq (keybord_irq)
   );

   always #5 clock = ~clock;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_bytes[$];
   logic [7:0] exp_codes[$];
   bit         chk_bytes = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input logic [31:0] act);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %0h", name, act);
   endtask

   // Forward XT -> Tandy conversion, written from the key table independently.
   function automatic logic [6:0] fwd(input logic pfx, input logic [6:0] x);
      logic [6:0] r;
      r = x;
      if (pfx) begin
         case (x)
            7'h48: r = 7'h29;
            7'h4B: r = 7'h2B;
            7'h50: r = 7'h4A;
            7'h4D: r = 7'h4E;
            7'h1C: r = 7'h57;
            7'h47: r = 7'h58;
            default: r = x;
         endcase
      end else begin
         case (x)
            7'h4A: r = 7'h53;
            7'h4E: r = 7'h55;
            7'h53: r = 7'h56;
            7'h57: r = 7'h59;
            7'h58: r = 7'h5A;
            default: r = x;
         endcase
      end
      return r;
   endfunction

   // Monitor: byte scoreboard on each irq rise, stability and pulse width on
   // each fall, and forward decode back to a Tandy code.
   initial begin
      logic       prev_irq;
      logic       pfx;
      logic [7:0] cap;
      logic [7:0] got;
      int         hi_cnt;
      prev_irq = 1'b0;
      pfx      = 1'b0;
      cap      = 8'h00;
      hi_cnt   = 0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            prev_irq = 1'b0;
            pfx      = 1'b0;
            hi_cnt   = 0;
         end else begin
            if (keybord_irq && !prev_irq) begin
               cap    = scancode;
               hi_cnt = 1;
               if (exp_bytes.size() > 0) check("byte", cap, exp_bytes.pop_front());
               else if (chk_bytes) fail_now("unexpected_byte", cap);
               if (cap == 8'hE0) begin
                  pfx = 1'b1;
               end else begin
                  got = {cap[7], fwd(pfx, cap[6:0])};
                  pfx = 1'b0;
                  if (exp_codes.size() > 0) check("loopback_code", got, exp_codes.pop_front());
                  else fail_now("unexpected_code", got);
               end
            end else if (keybord_irq) begin
               hi_cnt++;
            end else if (prev_irq) begin
               check("scancode_stable", scancode, cap);
               check("irq_high_cycles", hi_cnt, 4);
            end
            prev_irq = keybord_irq;
         end
      end
   end

   task automatic offer(input logic [7:0] code);
      int w;
      w = 0;
      @(negedge clock);
      while (!tif.tandy_ready && w < 100) begin
         @(negedge clock);
         w++;
      end
      if (!tif.tandy_ready) fail_now("offer_timeout", code);
      tif.tandy_code  = code;
      tif.tandy_valid = 1'b1;
      @(posedge clock);
      #1 tif.tandy_valid = 1'b0;
   endtask

   task automatic wait_ready(input int exp_n, input string name);
      int n;
      n = 0;
      @(negedge clock);
      while (!tif.tandy_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (!tif.tandy_ready) fail_now("ready_timeout", n);
      else if (exp_n >= 0) check(name, n, exp_n);
   endtask

   initial begin
      tif.tandy_code  = 8'h00;
      tif.tandy_valid = 1'b0;
      #12;
      check("reset_scancode", scancode, 8'h00);
      check("reset_irq", keybord_irq, 1'b0);
      check("reset_ready", tif.tandy_ready, 1'b1);
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // Unprefixed make code
      exp_bytes.push_back(8'h1E); exp_codes.push_back(8'h1E);
      offer(8'h1E); wait_ready(8, "ready_after_1E");

      // Prefixed make code (up arrow)
      exp_bytes.push_back(8'hE0); exp_bytes.push_back(8'h48); exp_codes.push_back(8'h29);
      offer(8'h29); wait_ready(16, "ready_after_29");

      // Break up arrow: prefix never carries the break bit
      exp_bytes.push_back(8'hE0); exp_bytes.push_back(8'hC8); exp_codes.push_back(8'hA9);
      offer(8'hA9); wait_ready(16, "ready_after_A9");

      // Break F11 -> D7
      exp_bytes.push_back(8'hD7); exp_codes.push_back(8'hD9);
      offer(8'hD9); wait_ready(8, "ready_after_D9");

      // Break keypad minus -> CA
      exp_bytes.push_back(8'hCA); exp_codes.push_back(8'hD3);
      offer(8'hD3); wait_ready(8, "ready_after_D3");

      // valid pulse with 4A during PRE_LO of 57 must be ignored
      exp_bytes.push_back(8'hE0); exp_bytes.push_back(8'h1C); exp_codes.push_back(8'h57);
      offer(8'h57);
      repeat (5) @(negedge clock);
      tif.tandy_code  = 8'h4A;
      tif.tandy_valid = 1'b1;
      @(negedge clock);
      tif.tandy_valid = 1'b0;
      wait_ready(-1, "ready_after_57");
      repeat (12) @(negedge clock);

      // Reset during PRE_HI of 58: E0 seen, 47 must never appear
      exp_bytes.push_back(8'hE0);
      offer(8'h58);
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      check("abort_irq", keybord_irq, 1'b0);
      check("abort_scancode", scancode, 8'h00);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      #1;
      check("abort_ready", tif.tandy_ready, 1'b1);
      repeat (30) @(negedge clock);
      check("abort_ready_idle", tif.tandy_ready, 1'b1);

      // Loopback: every make and break code except the one equal to E0
      chk_bytes = 1'b0;
      for (int c = 0; c < 256; c++) begin
         if (c != 8'hE0) begin
            exp_codes.push_back(8'(c));
            offer(8'(c));
            wait_ready(-1, "ready_loop");
         end
      end

      repeat (20) @(negedge clock);
      check("bytes_left", exp_bytes.size(), 0);
      check("codes_left", exp_codes.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
